// File: rtl/sequential_divider_if.sv
// Request/result bundle for sequential_divider.
// The Sinal operand only exists when DIVIDER_SIGNED_EN is defined.
interface sequential_divider_if #(parameter int WIDTH = 16);
    logic             Start;
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
`ifdef DIVIDER_SIGNED_EN
    logic             Sinal;
`endif
    logic [WIDTH-1:0] Quociente;
    logic [WIDTH-1:0] Resto;
    logic             Ocupado;
    logic             Pronto;
    logic             DivZero;

`ifdef DIVIDER_SIGNED_EN
    modport master (output Start, Dividendo, Divisor, Sinal,
                    input  Quociente, Resto, Ocupado, Pronto, DivZero);
    modport slave  (input  Start, Dividendo, Divisor, Sinal,
                    output Quociente, Resto, Ocupado, Pronto, DivZero);
`else
    modport master (output Start, Dividendo, Divisor,
                    input  Quociente, Resto, Ocupado, Pronto, DivZero);
    modport slave  (input  Start, Dividendo, Divisor,
                    output Quociente, Resto, Ocupado, Pronto, DivZero);
`endif
endinterface

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, WIDTH iterations.
// Define DIVIDER_SIGNED_EN to add two's-complement division selected by Sinal.
module sequential_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sequential_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, d;
    logic             neg_q, neg_r, div_zero;
    logic [WIDTH:0]   r_sh, r_sub;
    logic             ge;
    logic             sa, sb;
    logic [WIDTH-1:0] a_in, b_in;

    // Operands are reduced to magnitudes on entry; signs are restored at the output.
`ifdef DIVIDER_SIGNED_EN
    assign sa = bus.Sinal & bus.Dividendo[WIDTH-1];
    assign sb = bus.Sinal & bus.Divisor[WIDTH-1];
`else
    assign sa = 1'b0;
    assign sb = 1'b0;
`endif
    assign a_in = sa ? (~bus.Dividendo + ONE) : bus.Dividendo;
    assign b_in = sb ? (~bus.Divisor + ONE) : bus.Divisor;

    assign r_sh  = {r, q[WIDTH-1]};
    assign r_sub = r_sh - {1'b0, d};
    assign ge    = (r_sh >= {1'b0, d});

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.Start) state_nxt = (bus.Divisor == '0) ? ZERO : CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            ZERO: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt      <= '0;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Start) begin
                    q        <= a_in;
                    d        <= b_in;
                    r        <= '0;
                    cnt      <= '0;
                    neg_q    <= sa ^ sb;
                    neg_r    <= sa;
                    div_zero <= 1'b0;
                end
                CALC: begin
                    r   <= ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                // Remainder reports the original dividend: undo the magnitude taken on entry.
                ZERO: begin
                    q        <= '1;
                    r        <= neg_r ? (~q + ONE) : q;
                    neg_q    <= 1'b0;
                    neg_r    <= 1'b0;
                    div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Quociente = neg_q ? (~q + ONE) : q;
    assign bus.Resto     = neg_r ? (~r + ONE) : r;
    assign bus.Ocupado   = (state == CALC) || (state == ZERO);
    assign bus.Pronto    = (state == DONE);
    assign bus.DivZero   = div_zero;
endmodule
